// File: rtl/i2c_bus_frontend.sv
// i2c_bus_frontend: synchronise, deglitch and decode the raw I2C pins for i2c_slave
module i2c_bus_frontend #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 2_500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_f,
   output logic sda_f,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic bus_busy,
   output logic timeout
);
   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [SYNC_STAGES-1:0] scl_s, sda_s;
   logic [FW-1:0] scl_cnt, sda_cnt;
   logic [WW-1:0] wd_cnt;
   logic scl_y, sda_y, scl_d, sda_d, start_c, stop_c, wd_hit;
   assign scl_y   = scl_s[SYNC_STAGES-1];
   assign sda_y   = sda_s[SYNC_STAGES-1];
   assign start_c = scl_f & scl_d & sda_d & ~sda_f;
   assign stop_c  = scl_f & scl_d & ~sda_d & sda_f;
   assign wd_hit  = bus_busy & ~scl_f & (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
   // bring both pins into the clk domain; idle bus (high) out of reset
   always_ff @(posedge clk)
      if (!rst_n) begin
         scl_s <= '1;
         sda_s <= '1;
      end else begin
         scl_s <= {scl_s[SYNC_STAGES-2:0], scl_i};
         sda_s <= {sda_s[SYNC_STAGES-2:0], sda_i};
      end
   // SCL deglitch: follow the synced level only after it differs for FILTER_CYCLES edges
   always_ff @(posedge clk)
      if (!rst_n) begin
         scl_f   <= 1'b1;
         scl_cnt <= '0;
      end else if (scl_y == scl_f) scl_cnt <= '0;
      else if (scl_cnt == FW'(FILTER_CYCLES - 1)) begin
         scl_f   <= scl_y;
         scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 1'b1;
   // SDA deglitch, same rule as SCL
   always_ff @(posedge clk)
      if (!rst_n) begin
         sda_f   <= 1'b1;
         sda_cnt <= '0;
      end else if (sda_y == sda_f) sda_cnt <= '0;
      else if (sda_cnt == FW'(FILTER_CYCLES - 1)) begin
         sda_f   <= sda_y;
         sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 1'b1;
   // edge/condition strobes, bus ownership and the SCL-stuck-low watchdog
   always_ff @(posedge clk)
      if (!rst_n) begin
         scl_d     <= 1'b1;
         sda_d     <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
         bus_busy  <= 1'b0;
         timeout   <= 1'b0;
         wd_cnt    <= '0;
      end else begin
         scl_d     <= scl_f;
         sda_d     <= sda_f;
         scl_rise  <= scl_f & ~scl_d;
         scl_fall  <= ~scl_f & scl_d;
         start_det <= start_c;
         stop_det  <= stop_c;
         timeout   <= wd_hit;
         bus_busy  <= start_c | (bus_busy & ~stop_c & ~wd_hit);
         wd_cnt    <= (bus_busy & ~scl_f & ~wd_hit) ? wd_cnt + 1'b1 : '0;
      end
endmodule

// File: tb/tb_i2c_bus_frontend.sv
// tb_i2c_bus_frontend: vector table, corner sequences and random stimulus against a reference model
module tb_i2c_bus_frontend;
   localparam int SC = 2;
   localparam int FC = 4;
   localparam int TO = 64;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scl_i = 1'b1;
   logic sda_i = 1'b1;
   logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic s;
      logic d;
      int n;
      logic [7:0] e;
   } vec_t;
   vec_t tbl[$];
   logic ps[$], pd[$];
   logic m_sf, m_df, m_sfd, m_dfd, m_rise, m_fall, m_start, m_stop, m_busy, m_to;
   int cyc = 0;
   int low_since = -1;

   i2c_bus_frontend #(.SYNC_STAGES(SC), .FILTER_CYCLES(FC), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i),
      .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
      .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      ps.delete();
      pd.delete();
      for (int i = 0; i < 8; i++) begin
         ps.push_back(1'b1);
         pd.push_back(1'b1);
      end
      {m_sf, m_df, m_sfd, m_dfd} = 4'b1111;
      {m_rise, m_fall, m_start, m_stop, m_busy, m_to} = 6'b0;
      low_since = -1;
   endtask

   // one clock edge of the reference: a filtered line flips once the last FC samples it saw
   // (pins delayed by SC edges) all disagree with it; conditions come from level history
   task automatic model_edge(input logic s, input logic d, input logic r);
      logic all_s, all_d, hit;
      cyc++;
      if (!r) begin
         model_reset();
         return;
      end
      all_s = 1'b1;
      all_d = 1'b1;
      for (int i = SC - 1; i < SC - 1 + FC; i++) begin
         if (ps[i] == m_sf) all_s = 1'b0;
         if (pd[i] == m_df) all_d = 1'b0;
      end
      hit = 1'b0;
      if (m_busy && !m_sf) begin
         if (low_since < 0) low_since = cyc;
         hit = (cyc - low_since + 1 == TO);
      end else low_since = -1;
      m_rise  = m_sf & ~m_sfd;
      m_fall  = ~m_sf & m_sfd;
      m_start = m_sf & m_sfd & m_dfd & ~m_df;
      m_stop  = m_sf & m_sfd & ~m_dfd & m_df;
      m_busy  = m_start ? 1'b1 : (m_stop | hit) ? 1'b0 : m_busy;
      m_to    = hit;
      m_sfd   = m_sf;
      m_dfd   = m_df;
      m_sf    = all_s ? ~m_sf : m_sf;
      m_df    = all_d ? ~m_df : m_df;
      ps.push_front(s);
      pd.push_front(d);
      void'(ps.pop_back());
      void'(pd.pop_back());
   endtask

   task automatic step(input logic s, input logic d, input logic r);
      scl_i = s;
      sda_i = d;
      rst_n = r;
      @(posedge clk);
      model_edge(s, d, r);
      #1;
      check("model", {24'b0, outs()}, {24'b0, m_sf, m_df, m_rise, m_fall, m_start, m_stop, m_busy, m_to});
   endtask

   task automatic add(input logic s, input logic d, input int n, input logic [7:0] e);
      vec_t v;
      v.s = s;
      v.d = d;
      v.n = n;
      v.e = e;
      tbl.push_back(v);
   endtask

   initial begin
      int lows, rises, falls, tos, to_at, n;
      logic s, d;
      model_reset();
      // reset with idle pins
      for (int i = 0; i < 3; i++) step(1, 1, 0);
      check("reset_state", {24'b0, outs()}, 32'hC0);
      // outputs after each segment: {scl_f,sda_f,rise,fall,start,stop,busy,timeout}
      add(1, 1, 10, 8'hC0);
      add(1, 0, 7, 8'h8A);
      add(1, 0, 2, 8'h82);
      add(0, 0, 7, 8'h12);
      add(0, 1, 7, 8'h42);
      add(1, 1, 7, 8'hE2);
      add(1, 0, 7, 8'h8A);
      add(0, 0, 7, 8'h12);
      add(1, 1, 7, 8'hE2);
      add(1, 0, 7, 8'h8A);
      add(1, 1, 7, 8'hC4);
      add(1, 0, 3, 8'hC0);
      add(1, 1, 8, 8'hC0);
      add(0, 0, 7, 8'h10);
      add(1, 0, 7, 8'hA0);
      add(1, 1, 7, 8'hC4);
      foreach (tbl[k]) begin
         for (int i = 0; i < tbl[k].n; i++) step(tbl[k].s, tbl[k].d, 1);
         check($sformatf("vec%0d", k), {24'b0, outs()}, {24'b0, tbl[k].e});
      end
      // 3-cycle SCL glitch is rejected
      lows = 0; rises = 0; falls = 0;
      for (int i = 0; i < 18; i++) begin
         step(i < 3 ? 1'b0 : 1'b1, 1, 1);
         lows += int'(!scl_f); rises += int'(scl_rise); falls += int'(scl_fall);
      end
      check("glitch3_low", lows, 0);
      check("glitch3_edges", rises + falls, 0);
      // 5-cycle SCL pulse passes intact
      lows = 0; rises = 0; falls = 0;
      for (int i = 0; i < 20; i++) begin
         step(i < 5 ? 1'b0 : 1'b1, 1, 1);
         lows += int'(!scl_f); rises += int'(scl_rise); falls += int'(scl_fall);
      end
      check("pulse5_low", lows, 5);
      check("pulse5_rise", rises, 1);
      check("pulse5_fall", falls, 1);
      // START, eight data clocks, STOP
      for (int i = 0; i < 8; i++) step(1, 0, 1);
      check("start_busy", bus_busy, 1);
      rises = 0; n = 0;
      for (int b = 0; b < 8; b++) begin
         d = logic'(b[0]);
         for (int i = 0; i < 8; i++) begin
            step(0, d, 1);
            rises += int'(scl_rise); n += int'(start_det | stop_det);
         end
         for (int i = 0; i < 8; i++) begin
            step(1, d, 1);
            rises += int'(scl_rise); n += int'(start_det | stop_det);
         end
      end
      check("data_rises", rises, 8);
      check("data_no_cond", n, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 1);
      for (int i = 0; i < 8; i++) step(1, 0, 1);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 1);
         n += int'(stop_det);
      end
      check("stop_once", n, 1);
      check("stop_idle", bus_busy, 0);
      // watchdog fires after TO low cycles, busy drops with it, only once
      for (int i = 0; i < 8; i++) step(1, 0, 1);
      tos = 0; to_at = -1;
      for (int i = 1; i <= 150; i++) begin
         step(0, 0, 1);
         if (timeout) begin
            tos++;
            if (to_at < 0) to_at = i;
            check("to_busy", bus_busy, 0);
         end
      end
      check("to_cycle", to_at, SC + FC + TO);
      check("to_count", tos, 1);
      for (int i = 0; i < 8; i++) step(1, 0, 1);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 1);
         n += int'(stop_det) + int'(bus_busy) + int'(timeout);
      end
      check("idle_stop", n, 1);
      // SCL low for TO-1 cycles: no timeout
      for (int i = 0; i < 8; i++) step(1, 0, 1);
      tos = 0;
      for (int i = 0; i < TO - 1; i++) begin
         step(0, 0, 1);
         tos += int'(timeout);
      end
      for (int i = 0; i < 80; i++) begin
         step(1, 0, 1);
         tos += int'(timeout);
      end
      check("near_to_none", tos, 0);
      check("near_to_busy", bus_busy, 1);
      // reset mid-transaction
      for (int i = 0; i < 8; i++) step(0, 0, 1);
      step(0, 0, 0);
      check("mid_reset", {24'b0, outs()}, 32'hC0);
      for (int i = 0; i < 3; i++) step(1, 1, 0);
      // random segments, occasional long SCL-low holds and resets
      s = 1'b1;
      d = 1'b1;
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 99) == 0) step(s, d, 0);
         if ($urandom_range(0, 1) == 1) s = ~s;
         else d = ~d;
         n = ($urandom_range(0, 19) == 0) ? 70 : $urandom_range(1, 12);
         for (int i = 0; i < n; i++) step(s, d, 1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_bus_frontend.md
# i2c_bus_frontend

Input-conditioning stage that sits directly upstream of `i2c_slave`. It synchronises the raw SCL and SDA pins into the `clk` domain and filters glitches from both lines. From the filtered lines it produces single-cycle SCL edge strobes and START/STOP detect strobes, tracks bus ownership with a busy flag, and runs an SCL-stuck-low watchdog. `i2c_slave` consumes the filtered levels and strobes in place of raw pins; the SDA tristate driver stays in the top level.

## Interface
- `SYNC_STAGES`, default 2: flip-flop synchroniser depth per line; legal range ≥ 2.
- `FILTER_CYCLES`, default 4: consecutive cycles a synchronised level must hold before the filtered line follows it; legal range ≥ 1.
- `TIMEOUT_CYCLES`, default 2_500_000 (25 ms at 100 MHz): SCL-low cycles while busy before a timeout; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  reset, synchronous, active-low.
- `scl_i`  in  1  raw SCL pin, asynchronous.
- `sda_i`  in  1  raw SDA pin (tristate readback), asynchronous.
- `scl_f`  out  1  filtered SCL level.
- `sda_f`  out  1  filtered SDA level.
- `scl_rise`  out  1  one-cycle strobe, filtered SCL 0→1.
- `scl_fall`  out  1  one-cycle strobe, filtered SCL 1→0.
- `start_det`  out  1  one-cycle strobe, START or repeated START.
- `stop_det`  out  1  one-cycle strobe, STOP.
- `bus_busy`  out  1  high between START and STOP or timeout.
- `timeout`  out  1  one-cycle strobe, SCL stuck low.

## Operation
- **Synchroniser:** `SYNC_STAGES` flops per line; every stage resets to 1 (idle bus).
- **Filter, per line:**
  - Keeps a counter of width clog2(`FILTER_CYCLES`+1).
  - Synchronised level equal to the filtered level: counter clears.
  - Synchronised level differs: counter increments.
  - Counter reaches `FILTER_CYCLES`: the filtered level takes the new value and the counter clears.
  - Any pulse shorter than `FILTER_CYCLES` cycles is rejected.
- **Edge strobes:**
  - Computed from the filtered levels and a one-cycle-delayed copy of each.
  - All outputs are registered.
- **START:** `sda_f` falls 1→0 while `scl_f` is high in both the current and the previous cycle.
- **STOP:** `sda_f` rises 0→1 under the same SCL condition as START.
- **Simultaneous events:**
  - SCL and SDA filtered levels changing in the same cycle produce neither START nor STOP; only the SCL edge strobe fires.
- **bus_busy:**
  - Set on `start_det`, including a repeated START while already busy (busy stays 1).
  - Cleared on `stop_det` or `timeout`.
  - A STOP while not busy still strobes `stop_det`; busy stays 0.
- **Watchdog:**
  - Counter of width clog2(`TIMEOUT_CYCLES`+1).
  - Increments each cycle that `bus_busy` is 1 and the filtered SCL is 0.
  - Clears when filtered SCL is 1 or `bus_busy` is 0.
  - On reaching `TIMEOUT_CYCLES`: strobe `timeout`, clear `bus_busy`, clear the counter. No further timeout until the next START.
  - No saturation or wrap is possible because the counter clears on hit.

## Timing
- **Reset values:**
  - `scl_f` = 1, `sda_f` = 1.
  - `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `timeout`, `bus_busy` = 0.
  - All counters = 0.
- **Reset behaviour:**
  - Takes effect on the first `clk` edge with `rst_n` low; aborts any operation mid-transaction.
  - A line held low across reset release appears as a filtered fall after the normal latency.
  - SDA low with SCL high at release therefore yields `start_det`. This is intended.
- **Pin-to-filtered latency:** a clean level change on a pin reaches `scl_f`/`sda_f` exactly `SYNC_STAGES` + `FILTER_CYCLES` clock edges later (6 at defaults), ±1 cycle for asynchronous sampling.
- **Strobe timing:**
  - `scl_rise`, `scl_fall`, `start_det` and `stop_det` assert in the cycle after the filtered level changes.
  - Each is high for exactly one cycle.
- **Timeout timing:**
  - `timeout` asserts exactly `TIMEOUT_CYCLES` cycles after the first busy cycle with filtered SCL low.
  - `bus_busy` reads 0 in the same cycle `timeout` is high.
- **Minimum resolvable SCL phase:** `FILTER_CYCLES` + 1 cycles (50 ns at 100 MHz, defaults), comfortably below a 400 kHz half-period.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `FILTER_CYCLES`=4, `TIMEOUT_CYCLES`=64.

1. **Reset:** hold `rst_n`=0 with pins at 1 → all strobes 0, `scl_f`=`sda_f`=1, `bus_busy`=0. Drive `rst_n`=0 mid-transaction → all outputs return to reset values next edge.
2. **Glitch rejection:**
   - 3-cycle low pulse on SCL → `scl_f` stays 1, no strobes.
   - 5-cycle low pulse → `scl_f` low for exactly 5 cycles; one `scl_fall` and one `scl_rise`, each one cycle wide.
3. **START/STOP:**
   - SCL high, SDA falls → `start_det` once, `bus_busy`=1.
   - Eight SCL clocks with data → 8 `scl_rise`, no start/stop.
   - SCL high, SDA rises → `stop_det` once, `bus_busy`=0.
4. **Repeated START and simultaneous edges:**
   - Repeated START mid-transfer → `start_det`, `bus_busy` stays 1.
   - SCL and SDA released in the same cycle → no `stop_det`.
5. **Watchdog:**
   - After START, hold SCL low 64 cycles → `timeout` in the 64th cycle, `bus_busy`=0.
   - Holding SCL low 63 cycles then releasing → no `timeout`.
6. **Idle STOP:** SDA rising with SCL high while not busy → `stop_det`=1, `bus_busy` remains 0, `timeout` never fires.
